// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding, address decode and error constants for the APB register slave
package apb_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  localparam int APB_ADDR_LSB = 2;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: register bank with one write port, a combinational read mux and a flat contents bus
module apb_regfile #(
  parameter int data_width = 32,
  parameter int num_regs   = 8,
  parameter int idx_w      = $clog2(num_regs)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [idx_w-1:0]               waddr_i,
  input  logic [data_width-1:0]          wdata_i,
  input  logic [idx_w-1:0]               raddr_i,
  output logic [data_width-1:0]          rdata_o,
  output logic [num_regs*data_width-1:0] regs_o
);
  logic [num_regs*data_width-1:0] regs_q;
  // registers clear on reset and take write data only on a qualified write
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) regs_q <= '0;
    else if (we_i) regs_q[int'(waddr_i)*data_width +: data_width] <= wdata_i;
  assign rdata_o = regs_q[int'(raddr_i)*data_width +: data_width];
  assign regs_o  = regs_q;
endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with programmable wait states in front of a register bank
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int addr_width  = 32,
  parameter int data_width  = 32,
  parameter int num_regs    = 8,
  parameter int wait_states = 1
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [addr_width-1:0]          PADDR,
  input  logic [data_width-1:0]          PWDATA,
  output logic [data_width-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [num_regs*data_width-1:0] regs_q
);
  localparam int idx_w = $clog2(num_regs);
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [idx_w-1:0]      idx_q, idx_d;
  logic                  write_q, write_d, err_q, err_d;
  logic [data_width-1:0] wdata_q, wdata_d, prdata_d, rdata;
  logic                  pready_d, pslverr_d, setup, we, rst_n;
  logic [1:0]            err_code, rst_sync_q;
  // reset asserts immediately and releases two clean edges later
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n    = rst_sync_q[1];
  assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
  assign err_code = (PADDR[1:0] != 2'b00) ? ERR_MISALIGN :
                    (|(PADDR >> (APB_ADDR_LSB + idx_w))) ? ERR_RANGE : ERR_NONE;
  // next state: latch on setup, count down waits, finish or abort back to IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    pready_d = 1'b0;
    we       = 1'b0;
    if (state_q == IDLE) begin
      if (setup) begin
        state_d  = ACCESS;
        cnt_d    = 4'(wait_states);
        idx_d    = PADDR[APB_ADDR_LSB +: idx_w];
        write_d  = PWRITE;
        wdata_d  = PWDATA;
        err_d    = err_code != ERR_NONE;
        pready_d = (wait_states == 0);
      end
    end else if (!PSEL || PREADY) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      we      = PSEL && PENABLE && PREADY && write_q && !err_q;
    end else begin
      cnt_d    = cnt_q - 4'd1;
      pready_d = cnt_q == 4'd1;
    end
  end
  // the response is prepared the edge before PREADY rises, from the values being latched
  assign prdata_d  = (pready_d && !write_d && !err_d) ? rdata : '0;
  assign pslverr_d = pready_d && err_d;
  // FSM, latched request and registered response outputs
  always_ff @(posedge PCLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
      PRDATA  <= prdata_d;
    end
  apb_regfile #(.data_width(data_width), .num_regs(num_regs), .idx_w(idx_w)) u_regfile (
    .clk_i  (PCLK),
    .rst_ni (rst_n),
    .we_i   (we),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .raddr_i(idx_d),
    .rdata_o(rdata),
    .regs_o (regs_q)
  );
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed and random APB transfers on a one-wait and a zero-wait slave against a register model
module tb_apb_reg_slave;
  logic        clk = 1'b0;
  logic        presetn;
  logic        psel[2], penable[2], pwrite[2], pready[2], pslverr[2];
  logic [31:0] paddr[2], pwdata[2], prdata[2];
  logic [255:0] regs[2];
  logic [31:0] mdl[2][8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.addr_width(32), .data_width(32), .num_regs(8), .wait_states(1)) u_ws1 (
    .PCLK(clk), .PRESET(presetn), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .regs_q(regs[0])
  );
  apb_reg_slave #(.addr_width(32), .data_width(32), .num_regs(8), .wait_states(0)) u_ws0 (
    .PCLK(clk), .PRESET(presetn), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .regs_q(regs[1])
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] flat(input int d);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = mdl[d][i];
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int          ws;
    bit          e;
    logic [31:0] exp_rd;
    ws = (d == 0) ? 1 : 0;
    e = (addr % 4 != 0) || (addr / 4 >= 8);
    exp_rd = 32'h0;
    if (!wr && !e) exp_rd = mdl[d][addr/4];
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    step();
    penable[d] = 1'b1; paddr[d] = $urandom; pwdata[d] = $urandom;
    for (int i = 0; i < ws; i++) begin
      chk("wait_pready", pready[d], 0);
      chk("wait_prdata", prdata[d], 0);
      step();
    end
    chk("pready", pready[d], 1);
    chk("pslverr", pslverr[d], e);
    if (!wr) chk("prdata", prdata[d], exp_rd);
    if (wr && !e) mdl[d][addr/4] = data;
    step();
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("pready_drop", pready[d], 0);
    chk("regs", regs[d], flat(d));
  endtask

  initial begin
    int          d;
    bit          wr;
    logic [31:0] addr;
    for (int k = 0; k < 2; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = 0; pwdata[k] = 0;
    end
    clear_model();
    presetn = 1'b0;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_pready", pready[k], 0);
      chk("rst_pslverr", pslverr[k], 0);
      chk("rst_prdata", prdata[k], 0);
      chk("rst_regs", regs[k], 0);
    end
    presetn = 1'b1;
    step(); step(); step();

    xfer(0, 1, 32'h04, 32'hDEADBEEF);
    chk("reg1_deadbeef", regs[0][32 +: 32], 32'hDEADBEEF);
    xfer(0, 0, 32'h04, 32'h0);
    xfer(1, 1, 32'h00, 32'h11);
    xfer(1, 1, 32'h1C, 32'h22);
    chk("reg0_11", regs[1][0 +: 32], 32'h11);
    chk("reg7_22", regs[1][224 +: 32], 32'h22);
    xfer(1, 0, 32'h1C, 32'h0);
    xfer(0, 1, 32'h20, 32'hFFFFFFFF);
    xfer(0, 0, 32'h02, 32'h0);
    xfer(1, 1, 32'h05, 32'h12345678);

    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h08; pwdata[0] = 32'hBAD0BAD0;
    step();
    psel[0] = 0; penable[0] = 0;
    chk("abort_wait", pready[0], 0);
    step();
    chk("abort_no_ready", pready[0], 0);
    step();
    chk("abort_regs", regs[0], flat(0));
    xfer(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 32'h08, 32'h0C0FFEE0);

    psel[1] = 1; penable[1] = 1; pwrite[1] = 1; paddr[1] = 32'h0; pwdata[1] = 32'hFFFF;
    step();
    chk("penable_idle0", pready[1], 0);
    step();
    chk("penable_idle1", pready[1], 0);
    psel[1] = 0; penable[1] = 0;
    step();
    chk("penable_idle_regs", regs[1], flat(1));

    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 9) * 4;
      if ($urandom_range(0, 4) == 0) addr = addr | $urandom_range(1, 3);
      xfer(d, wr, addr, $urandom);
      if ($urandom_range(0, 1) == 1) step();
    end

    xfer(0, 1, 32'h0C, 32'hA5);
    psel[0] = 1; penable[0] = 0; pwrite[0] = 0; paddr[0] = 32'h0C;
    step();
    penable[0] = 1;
    step();
    chk("pre_rst_pready", pready[0], 1);
    chk("pre_rst_prdata", prdata[0], 32'hA5);
    presetn = 1'b0;
    #1;
    chk("midrst_pready", pready[0], 0);
    chk("midrst_prdata", prdata[0], 0);
    chk("midrst_pslverr", pslverr[0], 0);
    chk("midrst_regs0", regs[0], 0);
    chk("midrst_regs1", regs[1], 0);
    psel[0] = 0; penable[0] = 0;
    clear_model();
    step(); step();
    presetn = 1'b1;
    step(); step(); step();
    xfer(0, 1, 32'h14, 32'h1234);
    xfer(0, 0, 32'h14, 32'h0);

    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h18; pwdata[0] = 32'h5A5A5A5A;
    step();
    penable[0] = 1;
    presetn = 1'b0;
    #1;
    psel[0] = 0; penable[0] = 0;
    clear_model();
    step(); step();
    presetn = 1'b1;
    step(); step(); step();
    chk("pending_write_dropped", regs[0], 0);
    xfer(0, 0, 32'h18, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
